// File: rtl/mag_power_controller.sv
// mag_power_controller: magnetron on/off state machine with slow-PWM power levels.
// Buttons are active-low; each press is a registered falling edge and acts once.
module mag_power_controller #(
    parameter int LEVELS      = 10,
    parameter int STEP_CYCLES = 4,
    parameter int LEVEL_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startn,
    input  logic               stopn,
    input  logic               clearn,
    input  logic               door_closed,
    input  logic               timer_done,
    input  logic [LEVEL_W-1:0] power_level,
    output logic               mag_on,
    output logic [1:0]         state,
    output logic               done,
    output logic [LEVEL_W-1:0] level_out
);
    localparam int WIN = LEVELS * STEP_CYCLES;
    localparam int CW  = $clog2(WIN);

    typedef enum logic [1:0] {IDLE = 2'b00, COOK = 2'b01, PAUSE = 2'b10, DONE = 2'b11} st_t;

    st_t               st, nxt;
    logic [2:0]        btn_cur, btn_prev, press;
    logic              start_p, stop_p, clear_p;
    logic [CW-1:0]     cnt;
    logic              pwm_q;
    logic [LEVEL_W-1:0] lvl_in;

    assign press = btn_prev & ~btn_cur;
    assign {start_p, stop_p, clear_p} = press;
    assign lvl_in = (power_level == '0 || int'(power_level) > LEVELS) ? LEVEL_W'(LEVELS) : power_level;

    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = (start_p && door_closed && !timer_done) ? COOK : IDLE;
            COOK:    nxt = clear_p ? IDLE : (!door_closed || stop_p) ? PAUSE : timer_done ? DONE : COOK;
            PAUSE:   nxt = clear_p ? IDLE : !door_closed ? PAUSE : stop_p ? IDLE : start_p ? COOK : PAUSE;
            DONE:    nxt = (|press || !door_closed) ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= IDLE;
            btn_cur   <= '1;
            btn_prev  <= '1;
            cnt       <= '0;
            pwm_q     <= 1'b0;
            done      <= 1'b0;
            level_out <= LEVEL_W'(LEVELS);
        end else begin
            btn_cur  <= {startn, stopn, clearn};
            btn_prev <= btn_cur;
            st       <= nxt;
            done     <= nxt == DONE;
            if (st == IDLE && nxt == COOK)
                level_out <= lvl_in;
            // Counter and PWM only advance while staying in COOK, so any entry restarts the window.
            cnt   <= (st == COOK && nxt == COOK) ? ((cnt == CW'(WIN - 1)) ? '0 : cnt + 1'b1) : '0;
            pwm_q <= st == COOK && nxt == COOK && int'(cnt) < int'(level_out) * STEP_CYCLES;
        end
    end

    assign mag_on = pwm_q & door_closed;
    assign state  = st;
endmodule
